finn_deadlock_report_arbiter: RTL and testbench

FINN_DEADLOCK_REPORT_ARBITER -- requirements
Module: finn_deadlock_report_arbiter

---
 rtl/finn_deadlock_report_arbiter_if.sv | 12 +
 rtl/finn_deadlock_report_arbiter.sv | 126 ++++++++++++
 tb/tb_finn_deadlock_report_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/finn_deadlock_report_arbiter_if.sv
// Report handshake between the deadlock arbiter and its downstream consumer.
// The master presents an index that stays stable until the slave accepts it.
interface finn_deadlock_report_arbiter_if #(
  parameter int IDX_W = 2
);
  logic             report_valid;
  logic [IDX_W-1:0] report_idx;
  logic             report_ready;

  modport master (output report_valid, report_idx, input report_ready);
  modport slave  (input report_valid, report_idx, output report_ready);
endinterface

// File: rtl/finn_deadlock_report_arbiter.sv
// Confirms persistent block signals from deadlock monitors, keeps sticky flags,
// and reports each newly confirmed monitor once, round-robin, over a valid/ready port.
//
// state  | meaning
// IDLE   | no report presented; picks the next pending monitor, if any
// REPORT | report_valid=1, report_idx held until report_ready
module finn_deadlock_report_arbiter #(
  parameter int N_MON  = 4,
  parameter int THRESH = 16,
  parameter int IDX_W  = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [N_MON-1:0]               block_sigs,
  finn_deadlock_report_arbiter_if.master rpt,
  output logic [N_MON-1:0]               confirmed,
  output logic                           deadlock
);

  localparam int            CW     = $clog2(THRESH + 1);
  localparam logic [CW-1:0] THR    = CW'(THRESH);
  localparam logic [CW-1:0] THR_M1 = CW'(THRESH - 1);

  typedef enum logic {IDLE, REPORT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q [N_MON];
  logic [N_MON-1:0] reported_q;
  logic [N_MON-1:0] pending;
  logic [N_MON-1:0] hit;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] probe;
  logic             found;
  logic             load;
  logic             handshake;

  assign pending          = confirmed & ~reported_q;
  assign rpt.report_valid = (state_q == REPORT);
  assign rpt.report_idx   = idx_q;

  // A monitor confirms on the edge that completes its THRESH-th blocked cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_MON; i++) begin
      hit[i] = enable & block_sigs[i] & (cnt_q[i] == THR_M1);
    end
  end

  always_comb begin
    pick  = '0;
    probe = '0;
    found = 1'b0;
    for (int k = 0; k < N_MON; k++) begin
      probe = IDX_W'((int'(rr_ptr_q) + k) % N_MON);
      if (!found && pending[probe]) begin
        pick  = probe;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          state_d = REPORT;
          load    = 1'b1;
        end
      end
      REPORT: begin
        if (rpt.report_ready) begin
          state_d   = IDLE;
          handshake = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_MON; i++) begin
      if (reset || clear || !enable || !block_sigs[i]) begin
        cnt_q[i] <= '0;
      end else if (cnt_q[i] != THR) begin
        cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      confirmed  <= '0;
      reported_q <= '0;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      deadlock   <= 1'b0;
    end else begin
      deadlock <= |confirmed;
      if (clear) begin
        // Abandons any outstanding report; the round-robin pointer survives.
        state_q    <= IDLE;
        confirmed  <= '0;
        reported_q <= '0;
      end else begin
        state_q   <= state_d;
        confirmed <= confirmed | hit;
        if (load) begin
          idx_q <= pick;
        end
        if (handshake) begin
          reported_q[idx_q] <= 1'b1;
          rr_ptr_q          <= (idx_q == IDX_W'(N_MON - 1)) ? '0 : idx_q + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_finn_deadlock_report_arbiter.sv
// Bench for finn_deadlock_report_arbiter: directed scenarios with hand-derived
// expectations, then randomized traffic against a run-length/queue reference model.
module tb_finn_deadlock_report_arbiter;
  localparam int N  = 4;
  localparam int T  = 4;
  localparam int IW = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         clear;
  logic [N-1:0] block_sigs;
  logic [N-1:0] confirmed;
  logic         deadlock;

  finn_deadlock_report_arbiter_if #(.IDX_W(IW)) rif ();

  finn_deadlock_report_arbiter #(.N_MON(N), .THRESH(T), .IDX_W(IW)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .block_sigs (block_sigs),
    .rpt        (rif),
    .confirmed  (confirmed),
    .deadlock   (deadlock)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: run length of enabled blocked cycles per monitor, sticky
  // flags, and a single outstanding report picked round-robin.
  int           m_run [N];
  bit [N-1:0]   m_conf;
  bit [N-1:0]   m_rep;
  bit           m_busy;
  int           m_idx;
  int           m_ptr;
  bit           m_dead;

  task automatic model_update();
    bit [N-1:0] pend;
    pend = m_conf & ~m_rep;
    if (reset) begin
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_conf = '0; m_rep = '0; m_busy = 0; m_idx = 0; m_ptr = 0; m_dead = 0;
      return;
    end
    m_dead = |m_conf;
    if (clear) begin
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_conf = '0; m_rep = '0; m_busy = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (enable && block_sigs[i]) begin
        m_run[i]++;
        if (m_run[i] == T) m_conf[i] = 1'b1;
      end else begin
        m_run[i] = 0;
      end
    end
    if (m_busy) begin
      if (rif.report_ready) begin
        m_rep[m_idx] = 1'b1;
        m_ptr        = (m_idx + 1) % N;
        m_busy       = 0;
      end
    end else if (pend != 0) begin
      for (int k = 0; k < N; k++) begin
        if (pend[(m_ptr + k) % N]) begin
          m_idx  = (m_ptr + k) % N;
          m_busy = 1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic tidy();
    block_sigs = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clear = 1'b1; block_sigs = '1; rif.report_ready = 1'b1;
    repeat (3) tick();
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if ({rif.report_valid, rif.report_idx, confirmed, deadlock} !== 8'b0) begin
        n_err++;
        $display("FAIL reset_hold: valid=%b idx=%0d conf=%b dl=%b, required all 0",
                 rif.report_valid, rif.report_idx, confirmed, deadlock);
      end
      tick();
    end
    reset = 1'b0; clear = 1'b0; block_sigs = '0; rif.report_ready = 1'b0;
    tick();
    n_vec++;
    if ({rif.report_valid, rif.report_idx, confirmed, deadlock} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_release: valid=%b idx=%0d conf=%b dl=%b, required all 0",
               rif.report_valid, rif.report_idx, confirmed, deadlock);
    end
  endtask

  task automatic test_single_confirm();
    enable = 1'b1; rif.report_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      block_sigs = (c < 4) ? 4'b0001 : 4'b0000;
      if (c == 3 || c == 4) begin
        n_vec++;
        if ({confirmed, deadlock, rif.report_valid} !== {(c == 4) ? 4'b0001 : 4'b0000, 2'b00}) begin
          n_err++;
          $display("FAIL single_c%0d: conf=%b dl=%b valid=%b, required conf=%b dl=0 valid=0",
                   c, confirmed, deadlock, rif.report_valid, (c == 4) ? 4'b0001 : 4'b0000);
        end
      end
      if (c == 5) begin
        n_vec++;
        if ({rif.report_valid, rif.report_idx, deadlock} !== {1'b1, 2'd0, 1'b1}) begin
          n_err++;
          $display("FAIL single_report: valid=%b idx=%0d dl=%b, required 1 0 1",
                   rif.report_valid, rif.report_idx, deadlock);
        end
      end
      if (c >= 6) begin
        n_vec++;
        if (rif.report_valid !== 1'b0) begin
          n_err++;
          $display("FAIL single_after_c%0d: valid=%b, required 0", c, rif.report_valid);
        end
      end
      tick();
    end
    tidy();
  endtask

  task automatic test_glitch();
    enable = 1'b1; rif.report_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      block_sigs = ((c < 3) || (c >= 4 && c < 7)) ? 4'b0100 : 4'b0000;
      n_vec++;
      if ({confirmed, rif.report_valid} !== 5'b0) begin
        n_err++;
        $display("FAIL glitch_c%0d: conf=%b valid=%b, required 0 0", c, confirmed, rif.report_valid);
      end
      tick();
    end
    tidy();
  endtask

  // rr_ptr is 1 here (monitor 0 was the last one reported).
  task automatic test_rr_backpressure();
    enable = 1'b1;
    for (int c = 0; c < 19; c++) begin
      block_sigs = (c < 4) ? 4'b1010 : 4'b0000;
      rif.report_ready = (c >= 10);
      if (c == 4) begin
        n_vec++;
        if (confirmed !== 4'b1010) begin
          n_err++;
          $display("FAIL rr_confirm: conf=%b, required 1010", confirmed);
        end
      end
      if ((c >= 5 && c <= 10) || c == 12) begin
        n_vec++;
        if ({rif.report_valid, rif.report_idx} !== {1'b1, (c == 12) ? 2'd3 : 2'd1}) begin
          n_err++;
          $display("FAIL rr_report_c%0d: valid=%b idx=%0d, required valid=1 idx=%0d",
                   c, rif.report_valid, rif.report_idx, (c == 12) ? 3 : 1);
        end
      end
      if (c == 11 || c >= 13) begin
        n_vec++;
        if (rif.report_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rr_idle_c%0d: valid=%b, required 0", c, rif.report_valid);
        end
      end
      tick();
    end
    tidy();
  endtask

  task automatic test_wrap();
    int got [$];
    enable = 1'b1; rif.report_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      block_sigs = (c < 4) ? 4'b0100 : ((c >= 7 && c < 11) ? 4'b1001 : 4'b0000);
      if (rif.report_valid === 1'b1) got.push_back(int'(rif.report_idx));
      tick();
    end
    n_vec++;
    if (got.size() != 3) begin
      n_err++;
      $display("FAIL wrap_count: %0d reports, required 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        int exp_idx;
        exp_idx = (k == 0) ? 2 : ((k == 1) ? 3 : 0);
        n_vec++;
        if (got[k] != exp_idx) begin
          n_err++;
          $display("FAIL wrap_order_%0d: idx=%0d, required %0d", k, got[k], exp_idx);
        end
      end
    end
    tidy();
  endtask

  task automatic test_clear_in_report();
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      block_sigs = (c < 4) ? 4'b0001 : 4'b0000;
      clear = (c == 6);
      rif.report_ready = (c == 6);
      if (c == 5 || c == 6) begin
        n_vec++;
        if ({rif.report_valid, rif.report_idx} !== 3'b100) begin
          n_err++;
          $display("FAIL clr_pre_c%0d: valid=%b idx=%0d, required 1 0", c, rif.report_valid, rif.report_idx);
        end
      end
      if (c == 7) begin
        n_vec++;
        if ({rif.report_valid, confirmed} !== 5'b0) begin
          n_err++;
          $display("FAIL clr_next: valid=%b conf=%b, required 0 0000", rif.report_valid, confirmed);
        end
      end
      if (c == 8) begin
        n_vec++;
        if ({deadlock, rif.report_valid} !== 2'b00) begin
          n_err++;
          $display("FAIL clr_deadlock: dl=%b valid=%b, required 0 0", deadlock, rif.report_valid);
        end
      end
      tick();
    end
    clear = 1'b0;
    rif.report_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      block_sigs = (r < 4) ? 4'b0001 : 4'b0000;
      if (r == 4 || r == 6) begin
        n_vec++;
        if (rif.report_valid !== 1'b0) begin
          n_err++;
          $display("FAIL reconf_idle_r%0d: valid=%b, required 0", r, rif.report_valid);
        end
      end
      if (r == 5) begin
        n_vec++;
        if ({rif.report_valid, rif.report_idx} !== 3'b100) begin
          n_err++;
          $display("FAIL reconf_report: valid=%b idx=%0d, required 1 0", rif.report_valid, rif.report_idx);
        end
      end
      tick();
    end
    tidy();
  endtask

  task automatic test_enable_low();
    enable = 1'b0; block_sigs = 4'b1111; rif.report_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      n_vec++;
      if ({confirmed, deadlock, rif.report_valid} !== 6'b0) begin
        n_err++;
        $display("FAIL en_low_c%0d: conf=%b dl=%b valid=%b, required 0", c, confirmed, deadlock, rif.report_valid);
      end
      tick();
    end
    enable = 1'b1;
    for (int e = 0; e < 5; e++) begin
      if (e == 3 || e == 4) begin
        n_vec++;
        if (confirmed !== ((e == 4) ? 4'b1111 : 4'b0000)) begin
          n_err++;
          $display("FAIL en_rise_e%0d: conf=%b, required %b", e, confirmed, (e == 4) ? 4'b1111 : 4'b0000);
        end
      end
      tick();
    end
    block_sigs = '0; rif.report_ready = 1'b1;
    repeat (12) tick();
    tidy();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      n_vec++;
      if ({confirmed, deadlock, rif.report_valid} !== {m_conf, m_dead, m_busy}) begin
        n_err++;
        $display("FAIL rand_c%0d: conf=%b dl=%b valid=%b, required conf=%b dl=%b valid=%b",
                 c, confirmed, deadlock, rif.report_valid, m_conf, m_dead, m_busy);
      end
      if (m_busy) begin
        n_vec++;
        if (rif.report_idx !== IW'(m_idx)) begin
          n_err++;
          $display("FAIL rand_idx_c%0d: idx=%0d, required %0d", c, rif.report_idx, m_idx);
        end
      end
      reset  = ($urandom_range(199) == 0);
      clear  = ($urandom_range(99) < 3);
      enable = ($urandom_range(99) < 95);
      rif.report_ready = ($urandom_range(99) < 50);
      for (int i = 0; i < N; i++) block_sigs[i] = ($urandom_range(99) < 85);
      tick();
    end
    reset = 1'b0; clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; block_sigs = '0; rif.report_ready = 1'b0;
    test_reset();
    test_single_confirm();
    test_glitch();
    test_rr_backpressure();
    test_wrap();
    test_clear_in_report();
    test_enable_low();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
